// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the instruction-memory request channel, the redirect channel and
//   the instruction-queue output channel of fetch_unit.
//
//   master : the fetch unit side (drives requests and queue head)
//   slave  : the environment (memory, branch unit, decode stage)
//
//   Signals
//     imem_req_o / imem_addr_o      fetch request and address
//     imem_ack_i / imem_data_i      same-cycle accept with instruction word
//     redirect_i / redirect_pc_i    restart fetch at a new address
//     instr_valid_o / instr_o /
//     instr_pc_o / instr_ready_i    queue head and pop handshake
//     count_o                       queue occupancy
// ----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [31:0]       imem_data_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              instr_valid_o;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] instr_pc_o;
    logic              instr_ready_i;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o,
        input  imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o,
        output imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Sequential instruction fetcher feeding a small instruction queue.
//   Issues one request per cycle while the queue has room, pushes returned
//   words with their address, and restarts on redirect. A redirect that
//   arrives while a request is outstanding parks the new address until the
//   stale request is acknowledged (FLUSH).
//
//   Ports
//     clk          single clock, rising edge
//     reset        synchronous, active-low
//     bus          fetch_unit_if.master (memory, redirect and queue channels)
//     align_err_o  one-cycle pulse on a misaligned redirect
//                  (only when FETCH_ALIGN_CHK_EN is defined)
//
//   Configuration macro
//     FETCH_ALIGN_CHK_EN : misaligned redirects halt fetch and raise
//                          align_err_o. Undefined: redirect_pc_i[1:0] are
//                          treated as zero.
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.master bus
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic        align_err_o
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

`ifdef FETCH_ALIGN_CHK_EN
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1} state_t;
`endif

    state_t             state_reg;
    logic [ADDR_W-1:0]  fetch_pc_reg;
    logic [ADDR_W-1:0]  pend_pc_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
`ifdef FETCH_ALIGN_CHK_EN
    logic               align_err_reg;
    logic               halt_hold_reg;   // request still outstanding while halted
    logic               misaligned;
`endif

    // Queue storage: small register file, read asynchronously so the head is
    // visible the cycle after it was written.
    logic [31:0]        instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    logic               req_int;
    logic               pending;
    logic               push;
    logic               pop;
    logic               q_valid;
    logic [ADDR_W-1:0]  redir_pc;

    // Low address bits never reach the fetch PC; with the alignment check
    // enabled a misaligned target is diverted to HALT before it is used.
    assign redir_pc = bus.redirect_pc_i & WORD_MASK;
`ifdef FETCH_ALIGN_CHK_EN
    assign misaligned = (bus.redirect_pc_i[1:0] != 2'b00);
`endif

    // The request only drops by count reaching DEPTH, which cannot happen
    // while a request is outstanding (no push without ack), so an issued
    // request is held until acknowledged.
    always_comb begin
        req_int = 1'b0;
        case (state_reg)
            ST_RUN:   req_int = (count_reg < CNT_W'(DEPTH));
            ST_FLUSH: req_int = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
            ST_HALT:  req_int = halt_hold_reg;
`endif
            default:  req_int = 1'b0;
        endcase
    end

    assign q_valid = (count_reg != '0);
    assign pending = req_int & ~bus.imem_ack_i;
    assign push    = reset & (state_reg == ST_RUN) & req_int & bus.imem_ack_i & ~bus.redirect_i;
    assign pop     = reset & q_valid & bus.instr_ready_i & ~bus.redirect_i;

    // Outputs are forced low during the reset cycle itself.
    assign bus.imem_req_o    = reset & req_int;
    assign bus.imem_addr_o   = fetch_pc_reg;
    assign bus.instr_valid_o = reset & q_valid;
    assign bus.instr_o       = instr_mem[rd_ptr_reg];
    assign bus.instr_pc_o    = pc_mem[rd_ptr_reg];
    assign bus.count_o       = count_reg;
`ifdef FETCH_ALIGN_CHK_EN
    assign align_err_o       = align_err_reg;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= bus.imem_data_i;
            pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_RUN;
            fetch_pc_reg  <= RESET_PC;
            pend_pc_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            align_err_reg <= 1'b0;
            halt_hold_reg <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ALIGN_CHK_EN
            align_err_reg <= 1'b0;
`endif
            if (bus.redirect_i) begin
                // Flush wins over any push or pop in the same cycle.
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
`ifdef FETCH_ALIGN_CHK_EN
                if (misaligned) begin
                    align_err_reg <= 1'b1;
                    halt_hold_reg <= pending;
                    state_reg     <= ST_HALT;
                end else
`endif
                if (pending) begin
                    pend_pc_reg <= redir_pc;
                    state_reg   <= ST_FLUSH;
                end else begin
                    fetch_pc_reg <= redir_pc;
                    state_reg    <= ST_RUN;
                end
            end else begin
                case (state_reg)
                    ST_RUN: begin
                        if (push) begin
                            fetch_pc_reg <= fetch_pc_reg + ADDR_W'(4);
                            wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                        end
                        if (pop) begin
                            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                        end
                        if (push && !pop) begin
                            count_reg <= count_reg + CNT_W'(1);
                        end else if (pop && !push) begin
                            count_reg <= count_reg - CNT_W'(1);
                        end
                    end
                    ST_FLUSH: begin
                        // Stale word is dropped; resume at the parked target.
                        if (bus.imem_ack_i) begin
                            fetch_pc_reg <= pend_pc_reg;
                            state_reg    <= ST_RUN;
                        end
                    end
`ifdef FETCH_ALIGN_CHK_EN
                    ST_HALT: begin
                        if (bus.imem_ack_i) begin
                            halt_hold_reg <= 1'b0;
                        end
                    end
`endif
                    default: state_reg <= ST_RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();
`ifdef FETCH_ALIGN_CHK_EN
    logic align_err;
`endif

    fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .align_err_o (align_err)
`endif
    );

    // One record per cycle: inputs, then outputs expected at mid-cycle.
    typedef struct {
        logic        rst_n;
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        keep;    // this cycle's ack data must be queued
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        cc;      // compare count this cycle
        logic [2:0]  e_cnt;
        logic        e_aerr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } sb_t;

    vec_t vecs[$];
    sb_t  exp_q[$];
    int   n_pass   = 0;
    int   n_checks = 0;

    function automatic vec_t mk(input logic r, input logic a, input logic rd,
                                input logic [31:0] rpc, input logic rdy, input logic k,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic cc, input logic [2:0] ec, input logic ae);
        vec_t v;
        v.rst_n = r;  v.ack = a;  v.redir = rd; v.rpc = rpc; v.ready = rdy; v.keep = k;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.cc = cc; v.e_cnt = ec; v.e_aerr = ae;
        return v;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, exp);
    endtask

    task automatic apply(input int id, input vec_t v);
        sb_t e;
        logic [31:0] data;
        data = $urandom;
        reset             = v.rst_n;
        bus.imem_ack_i    = v.ack;
        bus.imem_data_i   = data;
        bus.redirect_i    = v.redir;
        bus.redirect_pc_i = v.rpc;
        bus.instr_ready_i = v.ready;
        @(negedge clk);
        chk("imem_req", id, {31'd0, bus.imem_req_o}, {31'd0, v.e_req});
        if (v.e_req) chk("imem_addr", id, bus.imem_addr_o, v.e_addr);
        chk("instr_valid", id, {31'd0, bus.instr_valid_o}, {31'd0, v.e_valid});
        if (v.cc) chk("count", id, {29'd0, bus.count_o}, {29'd0, v.e_cnt});
`ifdef FETCH_ALIGN_CHK_EN
        chk("align_err", id, {31'd0, align_err}, {31'd0, v.e_aerr});
`endif
        if (!v.rst_n || v.redir) begin
            exp_q.delete();
        end else begin
            if (v.e_valid && v.ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_pop (step %0d): got pc %h, expected nothing queued", id, bus.instr_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    $display("pop  step %0d pc=%h instr=%h", id, bus.instr_pc_o, bus.instr_o);
                    chk("instr_pc", id, bus.instr_pc_o, e.pc);
                    chk("instr", id, bus.instr_o, e.data);
                end
            end
            if (v.keep) begin
                e.pc = v.e_addr;
                e.data = data;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.imem_ack_i = 1'b0; bus.imem_data_i = '0; bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0; bus.instr_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // rst, ack, redir, rpc, ready, keep | req, addr, valid, cc, cnt, aerr
        vecs.push_back(mk(L,H,L,32'h0,H,L, L,32'h0,L,H,3'd0,L));
        // streaming, one instruction per cycle
        vecs.push_back(mk(H,H,L,32'h0,H,H, H,32'h0,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,H,H, H,32'h4,H,H,3'd1,L));
        vecs.push_back(mk(H,H,L,32'h0,H,H, H,32'h8,H,H,3'd1,L));
        // reset again, then fill the queue with ready low
        vecs.push_back(mk(L,H,L,32'h0,H,L, L,32'h0,L,L,3'd0,L));
        vecs.push_back(mk(L,H,L,32'h0,H,L, L,32'h0,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'h0,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'h4,H,H,3'd1,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'h8,H,H,3'd2,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'hC,H,H,3'd3,L));
        vecs.push_back(mk(H,H,L,32'h0,L,L, L,32'h0,H,H,3'd4,L));
        vecs.push_back(mk(H,H,L,32'h0,H,L, L,32'h0,H,H,3'd4,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'h10,H,H,3'd3,L));
        vecs.push_back(mk(H,L,L,32'h0,L,L, L,32'h0,H,H,3'd4,L));
        // drain with request pending and no ack
        vecs.push_back(mk(H,L,L,32'h0,H,L, L,32'h0,H,H,3'd4,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h14,H,H,3'd3,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h14,H,H,3'd2,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h14,H,H,3'd1,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h14,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,H,H, H,32'h14,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,H,H, H,32'h18,H,H,3'd1,L));
        vecs.push_back(mk(H,H,L,32'h0,H,H, H,32'h1C,H,H,3'd1,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h20,H,H,3'd1,L));
        // redirect while 0x20 pending -> FLUSH
        vecs.push_back(mk(H,L,H,32'h100,H,L, H,32'h20,L,H,3'd0,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h20,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,H,L, H,32'h20,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'h100,L,H,3'd0,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h104,H,H,3'd1,L));
        // two redirects during FLUSH, newest wins
        vecs.push_back(mk(H,L,H,32'h200,H,L, H,32'h104,L,H,3'd0,L));
        vecs.push_back(mk(H,L,H,32'h300,H,L, H,32'h104,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,H,L, H,32'h104,L,H,3'd0,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h300,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,H,H, H,32'h300,L,H,3'd0,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h304,H,H,3'd1,L));
        // redirect in the ack cycle: data dropped, stays RUN
        vecs.push_back(mk(H,H,H,32'h400,H,L, H,32'h304,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'h400,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'h404,H,H,3'd1,L));
        // redirect flushes a non-empty queue, pop ignored
        vecs.push_back(mk(H,L,H,32'h500,H,L, H,32'h408,H,H,3'd2,L));
        vecs.push_back(mk(H,H,L,32'h0,H,L, H,32'h408,L,H,3'd0,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h500,L,H,3'd0,L));
        // address wrap
        vecs.push_back(mk(H,H,H,32'hFFFF_FFFC,H,L, H,32'h500,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,L,H, H,32'hFFFF_FFFC,L,H,3'd0,L));
        vecs.push_back(mk(H,H,L,32'h0,H,H, H,32'h0,H,H,3'd1,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h4,H,H,3'd1,L));
`ifndef FETCH_ALIGN_CHK_EN
        // low target bits ignored
        vecs.push_back(mk(H,H,H,32'h102,H,L, H,32'h4,L,H,3'd0,L));
        vecs.push_back(mk(H,L,L,32'h0,H,L, H,32'h100,L,H,3'd0,L));
`endif

        foreach (vecs[i]) apply(i, vecs[i]);

        // Reset in the middle of FLUSH drops the stale request and pend_pc.
        apply(100, mk(L,L,L,32'h0,H,L, L,32'h0,L,H,3'd0,L));
        apply(101, mk(L,L,L,32'h0,H,L, L,32'h0,L,H,3'd0,L));
        apply(102, mk(H,L,L,32'h0,H,L, H,32'h0,L,H,3'd0,L));
        apply(103, mk(H,L,H,32'h600,H,L, H,32'h0,L,H,3'd0,L));
        apply(104, mk(H,L,L,32'h0,H,L, H,32'h0,L,H,3'd0,L));
        apply(105, mk(L,L,L,32'h0,H,L, L,32'h0,L,H,3'd0,L));
        apply(106, mk(H,L,L,32'h0,H,L, H,32'h0,L,H,3'd0,L));
        apply(107, mk(H,H,L,32'h0,H,H, H,32'h0,L,H,3'd0,L));
        apply(108, mk(H,L,L,32'h0,H,L, H,32'h4,H,H,3'd1,L));

`ifdef FETCH_ALIGN_CHK_EN
        // Misaligned redirect -> HALT; only an aligned redirect resumes.
        apply(200, mk(H,H,H,32'h102,H,L, H,32'h4,L,H,3'd0,L));
        apply(201, mk(H,L,L,32'h0,H,L, L,32'h0,L,H,3'd0,H));
        apply(202, mk(H,L,L,32'h0,H,L, L,32'h0,L,H,3'd0,L));
        apply(203, mk(H,L,H,32'h106,H,L, L,32'h0,L,H,3'd0,L));
        apply(204, mk(H,L,H,32'h104,H,L, L,32'h0,L,H,3'd0,H));
        apply(205, mk(H,H,L,32'h0,H,H, H,32'h104,L,H,3'd0,L));
        apply(206, mk(H,L,L,32'h0,H,L, H,32'h108,H,H,3'd1,L));
        // misaligned while pending: request held until ack, then dropped
        apply(207, mk(H,L,H,32'h10A,H,L, H,32'h108,L,H,3'd0,L));
        apply(208, mk(H,L,L,32'h0,H,L, H,32'h108,L,H,3'd0,H));
        apply(209, mk(H,H,L,32'h0,H,L, H,32'h108,L,H,3'd0,L));
        apply(210, mk(H,L,L,32'h0,H,L, L,32'h0,L,H,3'd0,L));
`endif

        chk("sb_left", 999, exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
